// File: rtl/ofifo_collector_pkg.sv
// Shared definitions for the MAC array output path (array, row, collector).
//   PSUM_BW : psum width per column
//   COL     : number of array columns
//   DEPTH   : default entries per collector column FIFO
//   psum_t  : one column psum
package ofifo_collector_pkg;
    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 8;

    typedef logic [PSUM_BW-1:0] psum_t;
endpackage

// File: rtl/ofifo_lane.sv
// Single-column synchronous FIFO with first-word fall-through.
//   clk, reset : clock, synchronous active-high reset (pointers only)
//   din, wr    : write data and strobe
//   pop        : advance read pointer (caller guarantees lane non-empty)
//   dout       : head entry (valid only while !empty)
//   empty/full : occupancy flags, combinational from pointers
//   ovf        : this cycle's write is being dropped (wr on full lane without pop)
module ofifo_lane #(
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               wr,
    input  logic               pop,
    output logic [psum_bw-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic               ovf
);
    localparam int AW = $clog2(depth);

    // Extra MSB distinguishes full from empty when indices coincide.
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [psum_bw-1:0] mem [depth];
    logic               push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // A pop in the same cycle frees the head slot, so a full lane still accepts.
    assign push  = wr && (!full || pop);
    assign ovf   = wr && full && !pop;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ofifo_collector.sv
// Collects skewed per-column psums from the MAC array south edge and
// re-aligns them into whole-row words through one FIFO per column.
//   clk, reset : clock, synchronous active-high reset
//   in, wr     : packed column psums and per-column write strobes
//   rd         : pop one aligned row word (ignored while !o_valid)
//   out        : aligned row word, zero while !o_valid
//   o_valid    : every column holds data
//   o_full     : any column is full
//   o_empty    : every column is empty
//   err_ovf    : sticky, a write was dropped on a full column
module ofifo_collector
    import ofifo_collector_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   err_ovf
);
    logic [col-1:0]              empty, full, ovf;
    logic [col-1:0][psum_bw-1:0] dout;
    logic                        pop;

    // All lanes advance together, and only once a complete row is present.
    assign o_valid = ~|empty;
    assign o_empty = &empty;
    assign o_full  = |full;
    assign pop     = rd && o_valid;

    for (genvar c = 0; c < col; c++) begin : g_lane
        ofifo_lane #(
            .psum_bw(psum_bw),
            .depth  (depth)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .din  (in[psum_bw*c +: psum_bw]),
            .wr   (wr[c]),
            .pop  (pop),
            .dout (dout[c]),
            .empty(empty[c]),
            .full (full[c]),
            .ovf  (ovf[c])
        );
        assign out[psum_bw*c +: psum_bw] = o_valid ? dout[c] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset)    err_ovf <= 1'b0;
        else if (|ovf) err_ovf <= 1'b1;
    end
endmodule

// File: tb/tb_ofifo_collector.sv
module tb_ofifo_collector;
    import ofifo_collector_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [COL*PSUM_BW-1:0] in;
    logic [COL-1:0]         wr;
    logic                   rd;
    logic [COL*PSUM_BW-1:0] out;
    logic                   o_valid, o_full, o_empty, err_ovf;

    ofifo_collector dut (
        .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
        .out(out), .o_valid(o_valid), .o_full(o_full), .o_empty(o_empty),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per column plus a sticky error flag.
    psum_t mq [COL][$];
    bit    merr;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_valid();
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [COL*PSUM_BW-1:0] e;
        bit v, f, em;
        v  = m_valid();
        f  = 1'b0;
        em = 1'b1;
        e  = '0;
        for (int c = 0; c < COL; c++) begin
            if (mq[c].size() == DEPTH) f = 1'b1;
            if (mq[c].size() != 0) em = 1'b0;
            if (v) e[c*PSUM_BW +: PSUM_BW] = mq[c][0];
        end
        chk({tag, ".out"},     128'(out),     128'(e));
        chk({tag, ".valid"},   128'(o_valid), 128'(v));
        chk({tag, ".full"},    128'(o_full),  128'(f));
        chk({tag, ".empty"},   128'(o_empty), 128'(em));
        chk({tag, ".err_ovf"}, 128'(err_ovf), 128'(merr));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input string tag, input logic rst, input logic [COL-1:0] w,
                        input logic [COL*PSUM_BW-1:0] d, input logic r);
        bit pop;
        reset = rst; wr = w; in = d; rd = r;
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < COL; c++) mq[c].delete();
            merr = 1'b0;
        end else begin
            pop = r && m_valid();
            for (int c = 0; c < COL; c++) begin
                bit full_c;
                full_c = (mq[c].size() == DEPTH);
                if (pop) void'(mq[c].pop_front());
                if (w[c]) begin
                    if (!full_c || pop) mq[c].push_back(d[c*PSUM_BW +: PSUM_BW]);
                    else merr = 1'b1;
                end
            end
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [COL*PSUM_BW-1:0] row_word(input int row);
        logic [COL*PSUM_BW-1:0] d;
        for (int c = 0; c < COL; c++) d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(16*row + c);
        return d;
    endfunction

    function automatic logic [COL*PSUM_BW-1:0] rand_word();
        logic [COL*PSUM_BW-1:0] d;
        for (int c = 0; c < COL; c++) d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
        return d;
    endfunction

    initial begin
        logic [COL*PSUM_BW-1:0] d;
        reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
        merr = 1'b0;

        // 1: reset then idle
        step("rst", 1'b1, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step("idle", 1'b0, '0, '0, 1'b0);

        // 2: skewed fill, one column per cycle
        for (int c = 0; c < COL; c++) begin
            d = '0;
            d[c*PSUM_BW +: PSUM_BW] = PSUM_BW'(16'h0100 + c);
            step("skew", 1'b0, COL'(1) << c, d, 1'b0);
        end
        chk("skew.valid_rise", 128'(o_valid), 128'(1));
        chk("skew.lane7", 128'(out[7*PSUM_BW +: PSUM_BW]), 128'(16'h0107));
        step("skew_pop", 1'b0, '0, '0, 1'b1);
        chk("skew.empty_after_pop", 128'(o_empty), 128'(1));

        // 3: fill to full, overflow on lane 3, drain in order
        for (int r = 0; r < DEPTH; r++) step("fill", 1'b0, '1, row_word(r), 1'b0);
        chk("fill.full", 128'(o_full), 128'(1));
        step("ovf", 1'b0, COL'(8), row_word(99), 1'b0);
        chk("ovf.sticky", 128'(err_ovf), 128'(1));
        step("ovf_hold", 1'b0, '0, '0, 1'b0);
        for (int r = 0; r < DEPTH; r++) begin
            chk("drain.row", 128'(out), 128'(row_word(r)));
            step("drain", 1'b0, '0, '0, 1'b1);
        end
        chk("drain.err_held", 128'(err_ovf), 128'(1));

        // 4: full with simultaneous pop and write
        step("rst4", 1'b1, '0, '0, 1'b0);
        for (int r = 0; r < DEPTH; r++) step("fill4", 1'b0, '1, row_word(r), 1'b0);
        step("wr_pop_full", 1'b0, '1, row_word(8), 1'b1);
        chk("wr_pop_full.full", 128'(o_full), 128'(1));
        chk("wr_pop_full.err", 128'(err_ovf), 128'(0));
        for (int r = 0; r < DEPTH; r++) step("drain4", 1'b0, '0, '0, 1'b1);
        chk("drain4.empty", 128'(o_empty), 128'(1));

        // 5: rd while one column missing is ignored
        step("part", 1'b0, COL'(8'h7F), row_word(5), 1'b0);
        step("part_rd", 1'b0, '0, '0, 1'b1);
        step("lane7", 1'b0, COL'(8'h80), row_word(5), 1'b0);
        chk("part.intact", 128'(out), 128'(row_word(5)));
        step("part_pop", 1'b0, '0, '0, 1'b1);

        // 6: reset mid-stream with writes active
        for (int r = 0; r < 5; r++) step("pre6", 1'b0, '1, row_word(r + 20), 1'b0);
        step("ovf6", 1'b0, '1, row_word(0), 1'b0);
        step("rst6", 1'b1, '1, row_word(30), 1'b0);
        chk("rst6.empty", 128'(o_empty), 128'(1));
        step("post6", 1'b0, '1, row_word(40), 1'b0);
        chk("post6.word", 128'(out), 128'(row_word(40)));

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic [COL-1:0] w;
            w = COL'($urandom);
            if ($urandom_range(0, 3) == 0) w = '1;
            step("rand", ($urandom_range(0, 199) == 0), w, rand_word(),
                 ($urandom_range(0, 99) < 40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
